// File: rtl/drum_arbiter.sv
// -----------------------------------------------------------------------------
// drum_arbiter
//   Two requesters share one DRUM approximate multiplier. The IDLE state
//   grants one requester and latches its operand pair. CALC registers the
//   product. DONE holds the result until the consumer takes it. On contention
//   the requester that was served least recently wins.
//
//   Ports
//     clk                     clock, rising edge
//     rst_n                   asynchronous active-low reset
//     req0_valid/req1_valid   requester has an operand pair
//     req0_ready/req1_ready   operand pair accepted this cycle
//     req0_a/req1_a  [N-1:0]  operand A (signed)
//     req0_b/req1_b  [M-1:0]  operand B (signed)
//     res_valid               result available
//     res_ready               consumer accepts result
//     res_data  [N+M-1:0]     approximate product
//     res_id                  requester that owns res_data
//     busy                    FSM not in IDLE
//
// drum_mult
//   Combinational DRUM multiplier. Signs are removed by ones complement. Each
//   magnitude of K bits or fewer is used exactly. A wider magnitude is reduced
//   to its leading K bits, and the lowest kept bit is forced to 1 to cancel the
//   truncation bias. The two segments are multiplied and the product is
//   shifted back. The sign is restored by ones complement.
// -----------------------------------------------------------------------------

module drum_mult #(
   parameter int K = 3,
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic [N-1:0]   a_i,
   input  logic [M-1:0]   b_i,
   output logic [N+M-1:0] p_o
);

   localparam int P = N + M;

   logic         sign_a, sign_b;
   logic [N-1:0] mag_a, seg_a;
   logic [M-1:0] mag_b, seg_b;
   int           lead_a, lead_b, sh_a, sh_b;
   logic [P-1:0] prod_raw, prod_shf;

   assign sign_a = a_i[N-1];
   assign sign_b = b_i[M-1];
   assign mag_a  = a_i ^ {N{sign_a}};
   assign mag_b  = b_i ^ {M{sign_b}};

   always_comb begin
      lead_a = 0;
      for (int i = 0; i < N; i++) begin
         if (mag_a[i]) lead_a = i;
      end
      sh_a  = 0;
      seg_a = mag_a;
      if (lead_a >= K) begin
         sh_a  = lead_a - K + 1;
         // Forcing the segment LSB to 1 centres the truncation error on zero.
         seg_a = (mag_a >> sh_a) | {{(N-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      lead_b = 0;
      for (int i = 0; i < M; i++) begin
         if (mag_b[i]) lead_b = i;
      end
      sh_b  = 0;
      seg_b = mag_b;
      if (lead_b >= K) begin
         sh_b  = lead_b - K + 1;
         seg_b = (mag_b >> sh_b) | {{(M-1){1'b0}}, 1'b1};
      end
   end

   assign prod_raw = P'(seg_a) * P'(seg_b);
   assign prod_shf = prod_raw << (sh_a + sh_b);
   assign p_o      = prod_shf ^ {P{sign_a ^ sign_b}};

endmodule

module drum_arbiter #(
   parameter int K = 3,
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   input  logic           req1_valid,
   output logic           req0_ready,
   output logic           req1_ready,
   input  logic [N-1:0]   req0_a,
   input  logic [N-1:0]   req1_a,
   input  logic [M-1:0]   req0_b,
   input  logic [M-1:0]   req1_b,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [N+M-1:0] res_data,
   output logic           res_id,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q, state_d;
   logic           last_id_q, last_id_d;
   logic [N-1:0]   opa_q, opa_d;
   logic [M-1:0]   opb_q, opb_d;
   logic           id_q, id_d;
   logic [N+M-1:0] res_data_q, res_data_d;
   logic           res_id_q, res_id_d;
   logic [N+M-1:0] prod;
   logic           grant0, grant1;

   drum_mult #(.K(K), .N(N), .M(M)) u_drum (
      .a_i (opa_q),
      .b_i (opb_q),
      .p_o (prod)
   );

   // On contention the requester not served last wins. last_id resets to 1,
   // so requester 0 wins the first contention.
   assign grant0 = req0_valid & (~req1_valid | last_id_q);
   assign grant1 = req1_valid & (~req0_valid | ~last_id_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_id_q  <= 1'b1;
         opa_q      <= '0;
         opb_q      <= '0;
         id_q       <= 1'b0;
         res_data_q <= '0;
         res_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_id_q  <= last_id_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         id_q       <= id_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_id_d  = last_id_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      id_d       = id_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0) begin
               opa_d   = req0_a;
               opb_d   = req0_b;
               id_d    = 1'b0;
               state_d = CALC;
            end else if (grant1) begin
               opa_d   = req1_a;
               opb_d   = req1_b;
               id_d    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            res_data_d = prod;
            res_id_d   = id_q;
            state_d    = DONE;
         end
         DONE: begin
            if (res_ready) begin
               last_id_d = res_id_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_drum_arbiter.sv
module tb_drum_arbiter;

   localparam int K = 3;
   localparam int N = 4;
   localparam int M = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           req0_valid = 1'b0, req1_valid = 1'b0;
   logic           req0_ready, req1_ready;
   logic [N-1:0]   req0_a = '0, req1_a = '0;
   logic [M-1:0]   req0_b = '0, req1_b = '0;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic [N+M-1:0] res_data;
   logic           res_id;
   logic           busy;

   typedef struct packed {
      logic           id;
      logic [N+M-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;

   drum_arbiter #(.K(K), .N(N), .M(M)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_a     (req0_a),
      .req1_a     (req1_a),
      .req0_b     (req0_b),
      .req1_b     (req1_b),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted result is checked against the queue.
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got id %0d data %0h expected no result", res_id, res_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("res_data", 32'(res_data), 32'(mon_e.data));
            chk("res_id", 32'(res_id), 32'(mon_e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (busy && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic single(input logic x, input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic [N+M-1:0] exp);
      int cyc;
      logic got, other;
      if (x == 1'b0) begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end
      sb_q.push_back({x, exp});
      got = 1'b0;
      other = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         got   = x ? req1_ready : req0_ready;
         other = x ? req0_ready : req1_ready;
         cyc++;
         if (!got) tick();
      end
      chk("ready_granted", 32'(got), 32'd1);
      chk("ready_other_low", 32'(other), 32'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("calc_res_valid", 32'(res_valid), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      chk("latency_res_valid", 32'(res_valid), 32'd1);
      wait_idle();
   endtask

   task automatic both_valid(input int n, input logic [N-1:0] a0, input logic [M-1:0] b0,
                             input logic [N-1:0] a1, input logic [M-1:0] b1);
      int cnt, cyc;
      req0_a = a0; req0_b = b0;
      req1_a = a1; req1_b = b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      cnt = 0;
      cyc = 0;
      while (cnt < n && cyc < 200) begin
         @(negedge clk);
         chk("one_grant", 32'(req0_ready & req1_ready), 32'd0);
         if (req0_ready | req1_ready) cnt++;
         cyc++;
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("contention_count", 32'(cnt), 32'(n));
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      res_ready = 1'b1;

      // Lone requester 0: 3*2
      single(1'b0, 4'h3, 4'h2, 8'h06);

      // Contention after reset: requester 0 first, then requester 1 (-2*3 -> ~3)
      do_reset();
      sb_q.push_back({1'b0, 8'h31});
      sb_q.push_back({1'b1, 8'hFC});
      both_valid(2, 4'h7, 4'h7, 4'hE, 4'h3);

      // Six back-to-back contended transactions alternate 0,1,0,1,0,1
      // req0: 5*6 = 0x1E ; req1: -7*4 -> ~(6*4) = 0xE7
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back({1'b0, 8'h1E});
         sb_q.push_back({1'b1, 8'hE7});
      end
      both_valid(6, 4'h5, 4'h6, 4'h9, 4'h4);

      // Sign boundaries: -8*-8 -> 7*7 ; -1*5 -> ~0
      single(1'b1, 4'h8, 4'h8, 8'h31);
      single(1'b0, 4'hF, 4'h5, 8'hFF);

      // Consumer stalls for 5 cycles in DONE
      res_ready = 1'b0;
      req0_a = 4'h2; req0_b = 4'h3; req0_valid = 1'b1;
      sb_q.push_back({1'b0, 8'h06});
      cyc = 0;
      @(negedge clk);
      while (!req0_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("stall_grant", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_a = 4'h1; req1_b = 4'h1; req1_valid = 1'b1;
      sb_q.push_back({1'b1, 8'h01});
      cyc = 0;
      @(negedge clk);
      while (!res_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_res_valid", 32'(res_valid), 32'd1);
         chk("stall_res_data", 32'(res_data), 32'h06);
         chk("stall_res_id", 32'(res_id), 32'd0);
         chk("stall_req0_ready", 32'(req0_ready), 32'd0);
         chk("stall_req1_ready", 32'(req1_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
         tick();
         @(negedge clk);
      end
      tick();
      res_ready = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("accept_resume", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      wait_idle();

      // Reset during CALC discards the pending result
      req1_a = 4'h1; req1_b = 4'h2; req1_valid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!req1_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_grant", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #2;
      chk("abort_busy_calc", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_res_valid", 32'(res_valid), 32'd0);
      chk("abort_res_data", 32'(res_data), 32'd0);
      req1_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sb_q.push_back({1'b0, 8'h31});
      sb_q.push_back({1'b1, 8'hFC});
      both_valid(2, 4'h7, 4'h7, 4'hE, 4'h3);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
